demux_router: RTL and testbench

- Parametrised, registered 1-to-N demultiplexer; successor to the combinational 1x4 demux.
- Routes a WIDTH-bit input word to one of CHANNELS output channels, using a valid/ready handshake and one holding register per channel.
- Two routing modes: directed (select input) and round-robin (internal pointer).
- Used as the fan-out stage that distributes sensor/event words to per-channel downstream logic, e.g. the entry/exit counter paths.

---
 rtl/demux_router_if.sv | 35 +++
 rtl/demux_router.sv | 108 ++++++++++
 tb/tb_demux_router.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_router_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_router_if
//  Description : Handshake/data bundle between a word source, the
//                demux_router fan-out stage and its per-channel consumers.
//                master = source/consumer side, slave = router side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface demux_router_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic                      in_valid;
    logic                      in_ready;
    logic [WIDTH-1:0]          in_data;
    logic [CHANNELS-1:0]       out_valid;
    logic [CHANNELS-1:0]       out_ready;
    logic [CHANNELS*WIDTH-1:0] out_data;
    logic                      drop;
    logic [SEL_W-1:0]          rr_ptr;

    modport master (
        output mode, sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, drop, rr_ptr
    );

    modport slave (
        input  mode, sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, drop, rr_ptr
    );
endinterface
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// ============================================================================
//  Module      : demux_router
//  Description : Registered 1-to-CHANNELS demultiplexer with valid/ready
//                handshake and one holding register per channel. Target is
//                either the sel input (mode=0) or an internal round-robin
//                pointer (mode=1). Words addressed to a non-existent channel
//                are discarded and flagged with a one-cycle drop pulse.
//                Optional build macro DEMUX_ZERO_IDLE_EN: a channel that
//                drains without a same-cycle load clears its data to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_router #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    demux_router_if.slave   bus
);

    // One extra bit so the channel count itself is representable for the
    // validity compare when CHANNELS is a power of two.
    localparam logic [SEL_W:0]   c_NUM_CH  = (SEL_W+1)'(CHANNELS);
    localparam logic [SEL_W-1:0] c_LAST_CH = SEL_W'(CHANNELS-1);

    logic [SEL_W-1:0]          w_tgt;
    logic                      w_tgt_ok;
    logic                      w_tgt_ready;
    logic                      w_in_ready;
    logic                      w_accept;
    logic [CHANNELS-1:0]       w_load;
    logic [CHANNELS-1:0]       w_out_valid;
    logic [CHANNELS*WIDTH-1:0] w_out_data;
    logic                      r_drop;
    logic [SEL_W-1:0]          r_rr_ptr;

    // Target selection, input-side readiness and per-channel load strobes.
    always_comb begin
        w_tgt       = bus.mode ? r_rr_ptr : bus.sel;
        w_tgt_ok    = ({1'b0, w_tgt} < c_NUM_CH);
        w_tgt_ready = 1'b1;
        w_load      = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_tgt == SEL_W'(k)) begin
                w_tgt_ready = ~w_out_valid[k] | bus.out_ready[k];
            end
        end
        w_in_ready = ~rst & w_tgt_ready;
        w_accept   = bus.in_valid & w_in_ready;
        for (int k = 0; k < CHANNELS; k++) begin
            w_load[k] = w_accept & w_tgt_ok & (w_tgt == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic             r_valid;
        logic [WIDTH-1:0] r_data;

        // Channel holding register: a load wins over a drain, so a channel
        // can take a new word every cycle while its consumer keeps up.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_data  <= '0;
            end else if (w_load[k]) begin
                r_valid <= 1'b1;
                r_data  <= bus.in_data;
            end else if (r_valid & bus.out_ready[k]) begin
                r_valid <= 1'b0;
`ifdef DEMUX_ZERO_IDLE_EN
                r_data  <= '0;
`endif
            end
        end

        assign w_out_valid[k]                 = r_valid;
        assign w_out_data[k*WIDTH +: WIDTH]   = r_data;
    end

    // Drop pulse: an accepted word had no channel to go to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_accept & ~w_tgt_ok;
        end
    end

    // Round-robin pointer: steps only on accepts in round-robin mode and
    // wraps at the last real channel, never skipping a stalled one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_accept & bus.mode) begin
            r_rr_ptr <= (r_rr_ptr == c_LAST_CH) ? '0 : r_rr_ptr + 1'b1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_out_data;
    assign bus.drop      = r_drop;
    assign bus.rr_ptr    = r_rr_ptr;

endmodule
`default_nettype wire

// File: tb/tb_demux_router.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_router
//  Description : Scoreboard bench for demux_router. A 4-channel instance
//                covers routing, back-pressure and round-robin behaviour; a
//                3-channel instance covers invalid-select drops and the
//                non-power-of-two pointer wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_router;

`ifdef DEMUX_ZERO_IDLE_EN
    localparam bit c_ZERO_IDLE = 1'b1;
`else
    localparam bit c_ZERO_IDLE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    demux_router_if #(.WIDTH(8), .CHANNELS(4)) a_if ();
    demux_router_if #(.WIDTH(8), .CHANNELS(3)) b_if ();

    demux_router #(.WIDTH(8), .CHANNELS(4)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    demux_router #(.WIDTH(8), .CHANNELS(3)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    typedef struct {
        int         ch;
        logic [7:0] d;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one word to instance A; the expected channel is given by the test.
    task automatic send(input bit m, input int s, input logic [7:0] d, input int exp_ch);
        int n;
        n = 0;
        a_if.mode     = m;
        a_if.sel      = 2'(s);
        a_if.in_data  = d;
        a_if.in_valid = 1'b1;
        @(negedge clk);
        while (!a_if.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!a_if.in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: word %h never accepted, expected in_ready=1", d);
        end else begin
            sb.push_back('{exp_ch, d});
        end
        @(posedge clk);
        #1;
        a_if.in_valid = 1'b0;
    endtask

    // Monitor: every transfer on instance A must match the oldest expected
    // word for that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (a_if.out_valid[k] && a_if.out_ready[k]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < sb.size(); i++) begin
                        if (sb[i].ch == k) begin
                            idx = i;
                            break;
                        end
                    end
                    n_checks++;
                    if (idx < 0) begin
                        n_fail++;
                        $display("FAIL scb_ch%0d: got unexpected word %h, expected none",
                                 k, a_if.out_data[k*8 +: 8]);
                    end else begin
                        if (a_if.out_data[k*8 +: 8] !== sb[idx].d) begin
                            n_fail++;
                            $display("FAIL scb_ch%0d: got %h, expected %h",
                                     k, a_if.out_data[k*8 +: 8], sb[idx].d);
                        end
                        sb.delete(idx);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b1;
        a_if.mode      = 1'b0;
        a_if.sel       = '0;
        a_if.in_data   = 8'h00;
        a_if.in_valid  = 1'b1;
        a_if.out_ready = 4'b1111;
        b_if.mode      = 1'b0;
        b_if.sel       = '0;
        b_if.in_data   = 8'h00;
        b_if.in_valid  = 1'b0;
        b_if.out_ready = 3'b111;

        // Reset with a pending word
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready",  32'(a_if.in_ready),  32'd0);
        check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
        check("rst_out_data",  a_if.out_data,       32'd0);
        check("rst_rr_ptr",    32'(a_if.rr_ptr),    32'd0);
        check("rst_drop",      32'(a_if.drop),      32'd0);
        @(posedge clk);
        #1;
        rst           = 1'b0;
        a_if.in_valid = 1'b0;

        // Directed routing
        send(1'b0, 0, 8'hA0, 0);
        send(1'b0, 1, 8'hA1, 1);
        send(1'b0, 2, 8'hA2, 2);
        send(1'b0, 3, 8'hA3, 3);
        @(posedge clk);
        @(negedge clk);
        check("dir_idle_valid", 32'(a_if.out_valid), 32'd0);
        check("drain_ch0_data", 32'(a_if.out_data[7:0]),   c_ZERO_IDLE ? 32'h00 : 32'hA0);
        check("drain_ch3_data", 32'(a_if.out_data[31:24]), c_ZERO_IDLE ? 32'h00 : 32'hA3);
        check("dir_rr_ptr",     32'(a_if.rr_ptr), 32'd0);

        // Back-pressure on channel 2
        @(posedge clk);
        #1;
        a_if.out_ready = 4'b1011;
        send(1'b0, 2, 8'h55, 2);
        a_if.mode     = 1'b0;
        a_if.sel      = 2'd2;
        a_if.in_data  = 8'h66;
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(a_if.in_ready),        32'd0);
            check("bp_hold",     32'(a_if.out_data[23:16]), 32'h55);
        end
        @(posedge clk);
        #1;
        a_if.out_ready = 4'b1111;
        send(1'b0, 2, 8'h66, 2);
        @(negedge clk);
        check("bp_ch2_next", 32'(a_if.out_data[23:16]), 32'h66);

        // Round-robin wrap
        @(posedge clk);
        #1;
        send(1'b1, 0, 8'h10, 0);
        send(1'b1, 0, 8'h11, 1);
        send(1'b1, 0, 8'h12, 2);
        send(1'b1, 0, 8'h13, 3);
        send(1'b1, 0, 8'h14, 0);
        send(1'b1, 0, 8'h15, 1);
        @(negedge clk);
        check("rr_wrap_ptr", 32'(a_if.rr_ptr), 32'd2);

        // Round-robin stall plus mode switch
        @(posedge clk);
        #1;
        a_if.out_ready = 4'b1101;
        send(1'b0, 1, 8'h30, 1);
        send(1'b1, 0, 8'h31, 2);
        send(1'b1, 0, 8'h32, 3);
        send(1'b1, 0, 8'h33, 0);
        a_if.mode     = 1'b1;
        a_if.in_data  = 8'h34;
        a_if.in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(a_if.in_ready), 32'd0);
            check("stall_rr_ptr",   32'(a_if.rr_ptr),   32'd1);
        end
        @(posedge clk);
        #1;
        send(1'b0, 3, 8'h35, 3);
        @(negedge clk);
        check("switch_rr_ptr", 32'(a_if.rr_ptr), 32'd1);
        check("switch_ch1_hold", 32'(a_if.out_data[15:8]), 32'h30);
        @(posedge clk);
        #1;
        a_if.out_ready = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_final_idle", 32'(a_if.out_valid), 32'd0);
        check("sb_empty",     32'(sb.size()),     32'd0);

        // Invalid select on the 3-channel instance
        @(posedge clk);
        #1;
        b_if.mode     = 1'b0;
        b_if.sel      = 2'd3;
        b_if.in_data  = 8'h77;
        b_if.in_valid = 1'b1;
        @(negedge clk);
        check("inv_in_ready", 32'(b_if.in_ready), 32'd1);
        check("inv_drop_pre", 32'(b_if.drop),     32'd0);
        @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        @(negedge clk);
        check("inv_drop",      32'(b_if.drop),      32'd1);
        check("inv_out_valid", 32'(b_if.out_valid), 32'd0);
        @(negedge clk);
        check("inv_drop_end",  32'(b_if.drop),      32'd0);

        // Round-robin wrap at a non-power-of-two channel count
        @(posedge clk);
        #1;
        b_if.mode     = 1'b1;
        b_if.in_data  = 8'h41;
        b_if.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        b_if.in_valid = 1'b0;
        @(negedge clk);
        check("b_rr_wrap",  32'(b_if.rr_ptr),           32'd0);
        check("b_ch2_load", 32'(b_if.out_data[23:16]),  32'h41);
        @(posedge clk);
        @(negedge clk);
        check("b_idle_valid",   32'(b_if.out_valid),       32'd0);
        check("b_drain_ch2",    32'(b_if.out_data[23:16]), c_ZERO_IDLE ? 32'h00 : 32'h41);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
